// File: rtl/bram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_read_arbiter
// Description : Two-client round-robin read arbiter in front of a single-port
//               BRAM; a 2-deep tag FIFO routes in-order responses to owners.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_read_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH-1:0] C0_REQ_ADDR,
    input  logic                  C0_REQ_EN,
    output logic                  C0_REQ_RDY,
    output logic [DATA_WIDTH-1:0] C0_RSP,
    output logic                  C0_RSP_RDY,
    input  logic                  C0_RSP_EN,
    input  logic [ADDR_WIDTH-1:0] C1_REQ_ADDR,
    input  logic                  C1_REQ_EN,
    output logic                  C1_REQ_RDY,
    output logic [DATA_WIDTH-1:0] C1_RSP,
    output logic                  C1_RSP_RDY,
    input  logic                  C1_RSP_EN,
    output logic [ADDR_WIDTH-1:0] MEM_RD_ADDR,
    output logic                  MEM_RD_EN,
    input  logic                  MEM_RD_RDY,
    input  logic [DATA_WIDTH-1:0] MEM_DOUT,
    input  logic                  MEM_DOUT_RDY,
    output logic                  MEM_DOUT_EN
);

    logic                  r_v0;
    logic                  r_v1;
    logic [ADDR_WIDTH-1:0] r_a0;
    logic [ADDR_WIDTH-1:0] r_a1;
    logic                  r_last;
    logic                  r_tag0;
    logic                  r_tag1;
    logic [1:0]            r_count;

    logic w_pop;
    logic w_can_issue;
    logic w_issue;
    logic w_grant;
    logic w_acc0;
    logic w_acc1;

    always_comb begin
        w_pop       = RST_N && (r_count != 2'd0) && (C0_RSP_EN || C1_RSP_EN);
        // A pop frees a tag slot in the same cycle, so a full FIFO can still issue.
        w_can_issue = RST_N && MEM_RD_RDY && ((r_count != 2'd2) || w_pop);
        w_grant     = (r_v0 && r_v1) ? ~r_last : r_v1;
        w_issue     = w_can_issue && (r_v0 || r_v1);

        MEM_RD_EN   = w_issue;
        MEM_RD_ADDR = (w_issue && w_grant) ? r_a1 : r_a0;
        MEM_DOUT_EN = w_pop;

        C0_REQ_RDY  = RST_N && (!r_v0 || (w_issue && !w_grant));
        C1_REQ_RDY  = RST_N && (!r_v1 || (w_issue && w_grant));
        w_acc0      = C0_REQ_EN && C0_REQ_RDY;
        w_acc1      = C1_REQ_EN && C1_REQ_RDY;

        C0_RSP_RDY  = RST_N && MEM_DOUT_RDY && (r_count != 2'd0) && !r_tag0;
        C1_RSP_RDY  = RST_N && MEM_DOUT_RDY && (r_count != 2'd0) && r_tag0;
        C0_RSP      = MEM_DOUT;
        C1_RSP      = MEM_DOUT;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_a0    <= '0;
            r_a1    <= '0;
            r_last  <= 1'b1;
            r_tag0  <= 1'b0;
            r_tag1  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            // A new request wins over the grant clearing the same buffer.
            if (w_acc0) begin
                r_v0 <= 1'b1;
                r_a0 <= C0_REQ_ADDR;
            end else if (w_issue && !w_grant) begin
                r_v0 <= 1'b0;
            end

            if (w_acc1) begin
                r_v1 <= 1'b1;
                r_a1 <= C1_REQ_ADDR;
            end else if (w_issue && w_grant) begin
                r_v1 <= 1'b0;
            end

            if (w_issue) begin
                r_last <= w_grant;
            end

            case ({w_issue, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_tag0 <= w_grant;
                    end else begin
                        r_tag1 <= w_grant;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_tag0  <= r_tag1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_tag0 <= w_grant;
                    end else begin
                        r_tag0 <= r_tag1;
                        r_tag1 <= w_grant;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bram_read_arbiter.md
# bram_read_arbiter

Two-client read-port arbiter placed directly upstream of the single-read-port BRAM. It buffers one read request per client, issues requests to the BRAM read port in round-robin order while respecting its RD_RDY credit, and records a tag per issued read. The tag steers each in-order BRAM response back to the client that issued it.

## Interface
- addr_width, 1, address width; matches the BRAM
- data_width, 1, data width; matches the BRAM
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  reset; RST_N synchronous, active-low; clock CLK
- C0_REQ_ADDR  in  addr_width  client 0 read address
- C0_REQ_EN  in  1  client 0 request strobe; legal only while C0_REQ_RDY=1
- C0_REQ_RDY  out  1  client 0 may issue a request
- C0_RSP  out  data_width  response data; equals MEM_DOUT
- C0_RSP_RDY  out  1  head response belongs to client 0
- C0_RSP_EN  in  1  client 0 consumes its response; legal only while C0_RSP_RDY=1
- C1_REQ_ADDR, C1_REQ_EN, C1_REQ_RDY, C1_RSP, C1_RSP_RDY, C1_RSP_EN: client 1, same directions, widths and meanings
- MEM_RD_ADDR  out  addr_width  BRAM read address
- MEM_RD_EN  out  1  BRAM read strobe
- MEM_RD_RDY  in  1  BRAM accepts a read
- MEM_DOUT  in  data_width  BRAM head response
- MEM_DOUT_RDY  in  1  BRAM response available
- MEM_DOUT_EN  out  1  dequeue BRAM response

## Operation
- State:
  - per client i: request buffer valid bit vi and address ai
  - round-robin pointer last (1 bit): the client granted most recently
  - tag FIFO: depth 2, 1-bit entries, with count 0..2
- Arbitration is combinational each cycle:
  - can_issue = MEM_RD_RDY && (count<2 || pop this cycle)
  - with one valid buffer, grant it
  - with both valid, grant client !last
  - with none valid, no grant
- Issue on a grant g:
  - MEM_RD_EN=1 and MEM_RD_ADDR=ag
  - push g into the tag FIFO, clear vg, set last<=g
- Otherwise MEM_RD_EN=0. MEM_RD_ADDR is don't-care; drive a0.
- Request accept:
  - Ci_REQ_RDY = !vi || (grant==i this cycle)
  - On Ci_REQ_EN: vi<=1 and ai<=Ci_REQ_ADDR. This takes priority over clearing vi when a grant and an accept hit the same buffer in one cycle.
- Response steering:
  - head = tag FIFO head
  - Ci_RSP_RDY = MEM_DOUT_RDY && count>0 && head==i
  - Ci_RSP = MEM_DOUT for both clients
  - MEM_DOUT_EN = C0_RSP_EN | C1_RSP_EN, which pops the tag FIFO
- A push and a pop in the same cycle leave count unchanged, including at count=2.
- MEM_DOUT_RDY with count=0 is a protocol error. Neither RSP_RDY asserts; the arbiter does not dequeue.
- Responses return strictly in issue order. A client whose response is not at the head waits, even if data for it is pending behind another client's unconsumed response.

## Timing
- Reset cycle (RST_N=0):
  - all Ci_REQ_RDY, Ci_RSP_RDY, MEM_RD_EN and MEM_DOUT_EN are forced 0
  - all vi are cleared, count is set to 0, last is set to 1 so client 0 wins the first tie
  - Ci_REQ_EN and Ci_RSP_EN are ignored
- First cycle after reset: Ci_REQ_RDY=1 for both clients.
- Request accepted at edge t: MEM_RD_EN is asserted earliest in cycle t+1. Arbiter latency is 1 cycle; there is no request bypass.
- Client latency is that 1 cycle plus the BRAM response latency. The BRAM response appears ≥2 cycles after MEM_RD_EN. The arbiter assumes no fixed latency, only in-order responses.
- Sustained throughput: 1 issue per cycle while can_issue holds, i.e. a single client can stream at full rate.
  - Issues are bounded by the BRAM credit of 2 outstanding reads.
  - Throughput is also bounded by tag count ≤2.
- When MEM_RD_RDY=0, buffers hold. Ci_REQ_RDY drops for any client whose buffer is full.
- Reset mid-operation:
  - all buffered and outstanding requests are discarded
  - the BRAM is reset by the same RST_N, so no stale responses remain

## Test plan
- Single read: reset, C0 requests addr 5 (mem[5]=0xA5). Required: MEM_RD_EN with addr 5 one cycle after accept; C0_RSP_RDY with 0xA5; C1_RSP_RDY stays 0.
- Tie: C0 addr 1 and C1 addr 2 in the same cycle after reset. Required: addr 1 issued first, addr 2 next cycle; C0 gets mem[1] and then C1 gets mem[2], in that order.
- Streaming: C0 issues addrs 0..7 back-to-back, consuming each response as soon as it is ready. Required: all 8 data words return in order; no more than 2 reads are outstanding at any time.
- Credit stall: hold MEM_RD_RDY=0 with both buffers full. Required: MEM_RD_EN=0 and both REQ_RDY=0; on release, alternating grants with C0 first if last=1.
- Head-of-line: C1 is issued then C0; C1 withholds RSP_EN for 5 cycles. Required: C0_RSP_RDY=0 throughout the stall; C0 gets its data the cycle after C1 consumes.
- Reset with 2 reads outstanding and both buffers valid. Required: all outputs 0 during reset; afterwards count=0, both REQ_RDY=1, no spurious RSP_RDY.
